// File: rtl/rv_branch_pkg.sv
// rv_branch_pkg: shared types and constants for the branch redirect controller
package rv_branch_pkg;

   typedef enum logic [1:0] {
      KIND_BRANCH = 2'b00,
      KIND_JAL    = 2'b01,
      KIND_JALR   = 2'b10,
      KIND_ILL    = 2'b11
   } req_kind_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_EVAL     = 2'b01,
      S_REDIRECT = 2'b10
   } state_e;

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational RV32I branch condition evaluator
module branch_cmp
   import rv_branch_pkg::*;
(
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic [2:0]  funct3_i,
   output logic        taken_o,
   output logic        illegal_o
);

   logic eq, lt_s, lt_u;

   // Compare once, then pick the condition; funct3 010/011 never take
   always_comb begin
      eq        = rs1_i == rs2_i;
      lt_s      = $signed(rs1_i) < $signed(rs2_i);
      lt_u      = rs1_i < rs2_i;
      illegal_o = funct3_i == 3'b010 || funct3_i == 3'b011;
      taken_o   = funct3_i == F3_BEQ  ? eq    :
                  funct3_i == F3_BNE  ? !eq   :
                  funct3_i == F3_BLT  ? lt_s  :
                  funct3_i == F3_BGE  ? !lt_s :
                  funct3_i == F3_BLTU ? lt_u  :
                  funct3_i == F3_BGEU ? !lt_u : 1'b0;
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: fetch PC owner that resolves branches/jumps and redirects fetch
module branch_redirect_ctrl
   import rv_branch_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_kind,
   input  logic [2:0]       req_funct3,
   input  logic [XLEN-1:0]  req_pc,
   input  logic [XLEN-1:0]  req_imm,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [XLEN-1:0]  req_rs2,
   output logic [XLEN-1:0]  pc,
   output logic             flush,
   output logic             link_valid,
   output logic [XLEN-1:0]  link_data,
   output logic             misalign_err,
   output logic             illegal_err,
   output logic [CNT_W-1:0] redirect_cnt
);

   state_e           state_q;
   req_kind_e        kind_q;
   logic [2:0]       f3_q;
   logic [XLEN-1:0]  rpc_q, imm_q, rs1_q, rs2_q;
   logic [XLEN-1:0]  pc_q, link_data_q;
   logic [CNT_W-1:0] cnt_q;
   logic             flush_q, link_valid_q, misalign_q, illegal_q;

   logic             cmp_taken, cmp_illegal;
   logic             taken, illegal, jump, redirect, misalign;
   logic [XLEN-1:0]  target, seq_pc;

   branch_cmp u_cmp (
      .rs1_i     (rs1_q),
      .rs2_i     (rs2_q),
      .funct3_i  (f3_q),
      .taken_o   (cmp_taken),
      .illegal_o (cmp_illegal)
   );

   // Resolve the latched request: taken/illegal, target and its alignment
   always_comb begin
      jump     = kind_q == KIND_JAL || kind_q == KIND_JALR;
      taken    = jump || (kind_q == KIND_BRANCH && cmp_taken);
      illegal  = kind_q == KIND_ILL || (kind_q == KIND_BRANCH && cmp_illegal);
      target   = kind_q == KIND_JALR ? (rs1_q + imm_q) & ~32'd1 : rpc_q + imm_q;
      seq_pc   = rpc_q + 32'd4;
      misalign = taken && target[1:0] != 2'b00;
      redirect = taken && !misalign;
   end

   // FSM, PC, latched request, pulse outputs and saturating redirect counter
   always_ff @(posedge clk) begin
      flush_q      <= 1'b0;
      link_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      illegal_q    <= 1'b0;
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= RESET_PC;
         link_data_q <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  kind_q  <= req_kind_e'(req_kind);
                  f3_q    <= req_funct3;
                  rpc_q   <= req_pc;
                  imm_q   <= req_imm;
                  rs1_q   <= req_rs1;
                  rs2_q   <= req_rs2;
                  state_q <= S_EVAL;
               end else if (step) begin
                  pc_q <= pc_q + 32'd4;
               end
            end
            S_EVAL: begin
               pc_q         <= redirect ? target : misalign ? rpc_q : seq_pc;
               flush_q      <= redirect;
               misalign_q   <= misalign;
               illegal_q    <= illegal;
               link_valid_q <= redirect && jump;
               if (redirect && jump) link_data_q <= seq_pc;
               if (redirect && !(&cnt_q)) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               state_q      <= redirect ? S_REDIRECT : S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready    = state_q == S_IDLE;
   assign pc           = pc_q;
   assign flush        = flush_q;
   assign link_valid   = link_valid_q;
   assign link_data    = link_data_q;
   assign misalign_err = misalign_q;
   assign illegal_err  = illegal_q;
   assign redirect_cnt = cnt_q;

endmodule
